// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: byte strobes are queued in a small FIFO and
// serialised LSB first; strobes arriving while the FIFO is full are dropped and flagged.
module uart_tx_buffered #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_AW      = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] txData,
   input  logic       txDataWr,
   output logic       tx,
   output logic       busy,
   output logic       fifoFull,
   output logic       overflow
);

   localparam int               DEPTH      = 2 ** FIFO_AW;
   localparam logic [FIFO_AW:0] COUNT_FULL = (FIFO_AW + 1)'(DEPTH);
   localparam logic [15:0]      BIT_LAST   = 16'(CLKS_PER_BIT - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   logic [7:0]         r_mem [DEPTH];
   logic [FIFO_AW-1:0] r_wr_ptr;
   logic [FIFO_AW-1:0] r_rd_ptr;
   logic [FIFO_AW:0]   r_count;
   logic [1:0]         r_state;
   logic [15:0]        r_bit_cnt;
   logic [2:0]         r_bit_idx;
   logic [7:0]         r_shift;
   logic               r_tx;
   logic               r_overflow;

   logic w_full;
   logic w_empty;
   logic w_wr;
   logic w_bit_end;
   logic w_pop;

   // Full is taken from the registered count, so a same-cycle pop never frees a slot.
   assign w_full    = (r_count == COUNT_FULL);
   assign w_empty   = (r_count == '0);
   assign w_wr      = txDataWr & ~w_full;
   assign w_bit_end = (r_bit_cnt == BIT_LAST);
   assign w_pop     = ~w_empty & ((r_state == S_IDLE) | ((r_state == S_STOP) & w_bit_end));

   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= txData;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_overflow <= txDataWr & w_full;
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_wr, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // tx is driven from the current state, so the line trails the FSM by one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_bit_cnt <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_tx      <= 1'b1;
      end else begin
         case (r_state)
            S_START: r_tx <= 1'b0;
            S_DATA:  r_tx <= r_shift[0];
            default: r_tx <= 1'b1;
         endcase

         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  r_shift   <= r_mem[r_rd_ptr];
                  r_state   <= S_START;
                  r_bit_cnt <= '0;
                  r_bit_idx <= '0;
               end
            end
            S_START: begin
               if (w_bit_end) begin
                  r_bit_cnt <= '0;
                  r_state   <= S_DATA;
               end else begin
                  r_bit_cnt <= r_bit_cnt + 16'd1;
               end
            end
            S_DATA: begin
               if (w_bit_end) begin
                  r_bit_cnt <= '0;
                  r_shift   <= {1'b0, r_shift[7:1]};
                  r_bit_idx <= r_bit_idx + 3'd1;
                  if (r_bit_idx == 3'd7) begin
                     r_state <= S_STOP;
                  end
               end else begin
                  r_bit_cnt <= r_bit_cnt + 16'd1;
               end
            end
            S_STOP: begin
               if (w_bit_end) begin
                  r_bit_cnt <= '0;
                  if (w_pop) begin
                     r_shift   <= r_mem[r_rd_ptr];
                     r_bit_idx <= '0;
                     r_state   <= S_START;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_bit_cnt <= r_bit_cnt + 16'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign tx       = r_tx;
   assign busy     = (r_state != S_IDLE) | ~w_empty;
   assign fifoFull = w_full;
   assign overflow = r_overflow;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: a timeline model (frame start times, acceptance by occupancy)
// predicts tx/busy/fifoFull/overflow after every clock edge.
module tb_uart_tx_buffered;

   localparam int CPB   = 4;
   localparam int AW    = 2;
   localparam int DEPTH = 4;
   localparam int FRAME = 10 * CPB;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] txData = 8'h00;
   logic       txDataWr = 1'b0;
   logic       tx;
   logic       busy;
   logic       fifoFull;
   logic       overflow;

   int vectors = 0;
   int miscompares = 0;
   int edge_no = 0;

   // Model: each accepted byte has an accept edge and the edge its start bit appears on tx.
   int         q_acc[$];
   int         q_start[$];
   logic [7:0] q_data[$];
   int         last_start = -1000;
   int         drop_edge = -1;

   uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
      .clk(clk), .rst(rst), .txData(txData), .txDataWr(txDataWr),
      .tx(tx), .busy(busy), .fifoFull(fifoFull), .overflow(overflow)
   );

   always #5 clk = ~clk;

   function automatic int m_occ(int e);
      int n = 0;
      for (int i = 0; i < q_acc.size(); i++)
         if (q_acc[i] <= e && q_start[i] - 1 > e) n++;
      return n;
   endfunction

   function automatic logic m_tx(int e);
      for (int i = 0; i < q_start.size(); i++) begin
         if (e >= q_start[i] && e < q_start[i] + FRAME) begin
            int p = (e - q_start[i]) / CPB;
            if (p == 0) return 1'b0;
            if (p == 9) return 1'b1;
            return q_data[i][p-1];
         end
      end
      return 1'b1;
   endfunction

   function automatic logic m_busy(int e);
      for (int i = 0; i < q_acc.size(); i++)
         if (q_acc[i] <= e && e <= q_start[i] + FRAME - 2) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic m_full(int e);
      return m_occ(e) == DEPTH;
   endfunction

   function automatic logic m_ovf(int e);
      return e == drop_edge;
   endfunction

   // Drives one cycle of stimulus, advances the model, and leaves time 1 after the edge.
   task automatic step(input logic wr, input logic [7:0] d, input logic rs);
      int s;
      txDataWr = wr;
      txData   = d;
      rst      = rs;
      @(posedge clk);
      edge_no++;
      if (rs) begin
         q_acc.delete(); q_start.delete(); q_data.delete();
         last_start = -1000;
         drop_edge  = -1;
      end else if (wr) begin
         if (m_occ(edge_no - 1) < DEPTH) begin
            s = (edge_no + 2 > last_start + FRAME) ? edge_no + 2 : last_start + FRAME;
            q_acc.push_back(edge_no);
            q_start.push_back(s);
            q_data.push_back(d);
            last_start = s;
         end else begin
            drop_edge = edge_no;
         end
      end
      #1;
      txDataWr = 1'b0;
      rst      = 1'b0;
   endtask

   task automatic test_reset();
      step(1'b0, 8'h00, 1'b1);
      step(1'b1, 8'hA5, 1'b1);
      vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx: tx=%b expected 1", tx); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: busy=%b expected 0", busy); end
      vectors++; if (fifoFull !== 1'b0) begin miscompares++; $display("FAIL reset_full: fifoFull=%b expected 0", fifoFull); end
      vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: overflow=%b expected 0", overflow); end
   endtask

   task automatic test_single();
      int k;
      step(1'b1, 8'h2A, 1'b0);
      k = edge_no;
      for (int c = 0; c < FRAME + 6; c++) begin
         step(1'b0, 8'h00, 1'b0);
         if (edge_no == k + 1) begin
            vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL single_latency_k1: tx=%b expected 1", tx); end
         end
         if (edge_no == k + 2) begin
            vectors++; if (tx !== 1'b0) begin miscompares++; $display("FAIL single_latency_k2: tx=%b expected 0", tx); end
         end
         vectors++; if (tx !== m_tx(edge_no)) begin miscompares++; $display("FAIL single_tx edge %0d: tx=%b expected %b", edge_no, tx, m_tx(edge_no)); end
         vectors++; if (busy !== m_busy(edge_no)) begin miscompares++; $display("FAIL single_busy edge %0d: busy=%b expected %b", edge_no, busy, m_busy(edge_no)); end
      end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_end: busy=%b expected 0", busy); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] msg [5];
      msg[0] = 8'h41; msg[1] = 8'h30; msg[2] = 8'h31; msg[3] = 8'h21; msg[4] = 8'h2A;
      for (int i = 0; i < 5; i++) step(1'b1, msg[i], 1'b0);
      for (int c = 0; c < 5 * FRAME + 4; c++) begin
         step(1'b0, 8'h00, 1'b0);
         vectors++; if (tx !== m_tx(edge_no)) begin miscompares++; $display("FAIL b2b_tx edge %0d: tx=%b expected %b", edge_no, tx, m_tx(edge_no)); end
         vectors++; if (busy !== m_busy(edge_no)) begin miscompares++; $display("FAIL b2b_busy edge %0d: busy=%b expected %b", edge_no, busy, m_busy(edge_no)); end
         vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL b2b_ovf edge %0d: overflow=%b expected 0", edge_no, overflow); end
      end
   endtask

   task automatic test_overflow();
      int pulses = 0;
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
         pulses += int'(overflow === 1'b1);
         vectors++; if (fifoFull !== m_full(edge_no)) begin miscompares++; $display("FAIL ovf_full edge %0d: fifoFull=%b expected %b", edge_no, fifoFull, m_full(edge_no)); end
      end
      for (int c = 0; c < 5 * FRAME + 4; c++) begin
         step(1'b0, 8'h00, 1'b0);
         pulses += int'(overflow === 1'b1);
         vectors++; if (tx !== m_tx(edge_no)) begin miscompares++; $display("FAIL ovf_tx edge %0d: tx=%b expected %b", edge_no, tx, m_tx(edge_no)); end
         vectors++; if (overflow !== m_ovf(edge_no)) begin miscompares++; $display("FAIL ovf_pulse edge %0d: overflow=%b expected %b", edge_no, overflow, m_ovf(edge_no)); end
      end
      vectors++; if (pulses != 1) begin miscompares++; $display("FAIL ovf_count: pulses=%0d expected 1", pulses); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ovf_busy_end: busy=%b expected 0", busy); end
   endtask

   task automatic test_stop_write();
      int e0 = edge_no + 1;
      for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
      while (edge_no < e0 + 40) step(1'b0, 8'h00, 1'b0);
      step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
      vectors++; if (fifoFull !== 1'b0) begin miscompares++; $display("FAIL stopwr_full: fifoFull=%b expected 0", fifoFull); end
      vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL stopwr_ovf: overflow=%b expected 0", overflow); end
      vectors++; if (m_occ(edge_no) != 3) begin miscompares++; $display("FAIL stopwr_accept: model occupancy=%0d expected 3", m_occ(edge_no)); end
      for (int c = 0; c < 4 * FRAME + 4; c++) begin
         step(1'b0, 8'h00, 1'b0);
         vectors++; if (tx !== m_tx(edge_no)) begin miscompares++; $display("FAIL stopwr_tx edge %0d: tx=%b expected %b", edge_no, tx, m_tx(edge_no)); end
         vectors++; if (busy !== m_busy(edge_no)) begin miscompares++; $display("FAIL stopwr_busy edge %0d: busy=%b expected %b", edge_no, busy, m_busy(edge_no)); end
      end
   endtask

   task automatic test_reset_midframe();
      int s = edge_no + 1 + 2;
      step(1'b1, 8'h55, 1'b0);
      step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
      step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
      while (edge_no < s + 4 * CPB) step(1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b1);
      vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL rstmid_tx: tx=%b expected 1", tx); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: busy=%b expected 0", busy); end
      for (int c = 0; c < 3 * FRAME; c++) begin
         step(1'b0, 8'h00, 1'b0);
         vectors++; if (tx !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_quiet edge %0d: tx=%b busy=%b expected 1 0", edge_no, tx, busy); end
      end
   endtask

   task automatic test_idle();
      step(1'b0, 8'h00, 1'b1);
      for (int c = 0; c < 100; c++) begin
         step(1'b0, 8'h00, 1'b0);
         vectors++; if (tx !== 1'b1 || busy !== 1'b0 || overflow !== 1'b0) begin miscompares++; $display("FAIL idle edge %0d: tx=%b busy=%b overflow=%b expected 1 0 0", edge_no, tx, busy, overflow); end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 1200; c++) begin
         if (c < 1000) step($urandom_range(0, 9) == 0 || (c % 200 < 8), 8'($urandom_range(0, 255)), 1'b0);
         else step(1'b0, 8'h00, 1'b0);
         vectors++; if (tx !== m_tx(edge_no)) begin miscompares++; $display("FAIL rand_tx edge %0d: tx=%b expected %b", edge_no, tx, m_tx(edge_no)); end
         vectors++; if (busy !== m_busy(edge_no)) begin miscompares++; $display("FAIL rand_busy edge %0d: busy=%b expected %b", edge_no, busy, m_busy(edge_no)); end
         vectors++; if (fifoFull !== m_full(edge_no)) begin miscompares++; $display("FAIL rand_full edge %0d: fifoFull=%b expected %b", edge_no, fifoFull, m_full(edge_no)); end
         vectors++; if (overflow !== m_ovf(edge_no)) begin miscompares++; $display("FAIL rand_ovf edge %0d: overflow=%b expected %b", edge_no, overflow, m_ovf(edge_no)); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow();
      test_stop_write();
      test_reset_midframe();
      test_idle();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
